irrigation_scheduler: RTL and testbench
=======================================

IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 SHALL have parameters, one per line:
  MIN_ON  8   minimum irrigation run, in ticks (1..255)
  FILL_TO  30   maximum fill time before fault, in ticks (1..255)
REQ-002 SHALL have ports, one per line:
  clk  in  1  single system clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  tick  in  1  one-cycle timebase pulse; all timing counts these pulses
  low  in  1  tank level at or above low sensor
  mid  in  1  tank level at or above mid sensor
  high  in  1  tank level at or above high sensor
  Us  in  1  soil dry, irrigation demand
  Ua  in  1  air humidity high
  T  in  1  temperature high
  ack  in  1  operator fault acknowledge, level
  watter_supply  out  1  fill valve open
  asp  out  1  sprinkler on
  got  out  1  dripper on
  error  out  1  sensor or fill fault latched
  alarme  out  1  operator alarm
  state  out  3  current FSM state code
REQ-003 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n; no other clock or reset.

Function
REQ-004 SHALL implement states IDLE=0, FILL=1, SPRINKLE=2, DRIP=3, FAULT=4; state output equals the current code.
REQ-005 SHALL treat sensors as inconsistent when (mid and not low) or (high and not mid).
REQ-006 SHALL register all outputs; each output reflects the state entered on the same clk edge, with one-cycle latency from sampled inputs.
REQ-007 IDLE priority, evaluated each cycle: inconsistent -> FAULT; else mid=0 -> FILL; else Us=1 and (T=1 or Ua=0) -> DRIP; else Us=1 -> SPRINKLE; else high=0 -> FILL; else stay.
REQ-008 FILL: watter_supply=1; inconsistent -> FAULT; high=1 -> IDLE; timer reaching FILL_TO -> FAULT.
REQ-009 SPRINKLE/DRIP: asp=1 or got=1 respectively; the mode is latched at entry and is never switched mid-run on Ua/T changes.
REQ-010 SPRINKLE/DRIP exit: inconsistent -> FAULT; low=0 -> IDLE immediately, ignoring MIN_ON; Us=0 and timer>=MIN_ON -> IDLE; otherwise stay.
REQ-011 FAULT: error=1, alarme active, and watter_supply, asp and got all 0; exits to IDLE only when ack=1 and sensors are consistent in the same cycle.
REQ-012 SHALL keep an 8-bit timer that is cleared on every state change, increments on tick, and saturates at 255 without wrapping.
REQ-013 SHALL never assert more than one of watter_supply, asp or got at once, and SHALL assert none outside FILL/SPRINKLE/DRIP.
REQ-014 When tick coincides with a transition, the timer SHALL clear (the clear takes priority over the increment).
REQ-015 ack outside FAULT SHALL be ignored.

Reset
REQ-016 rst_n=0 SHALL immediately force state=IDLE, timer=0 and all outputs 0, including mid-fill or mid-irrigation; the alarme blink phase SHALL also clear to 0.
REQ-017 After rst_n is deasserted, the first evaluation SHALL occur on the next clk rising edge.

Configuration
REQ-018 With macro IRRIG_ALARM_BLINK_EN defined, alarme in FAULT SHALL toggle on each tick, starting at 1 on FAULT entry.
REQ-019 Without IRRIG_ALARM_BLINK_EN, alarme in FAULT SHALL be held at 1.
REQ-020 In both builds, alarme SHALL be 0 outside FAULT.

Verification
REQ-021 Fill path: low=mid=high=0, Us=0 -> FILL with watter_supply=1; set low,mid,high=1 at tick 5 -> IDLE, watter_supply=0.
REQ-022 Fill timeout: FILL with high held 0 for 30 ticks -> FAULT, error=1, watter_supply=0; ack=1 with consistent sensors -> IDLE.
REQ-023 Minimum run: low=mid=1, Us=1, T=0, Ua=1 -> SPRINKLE; drop Us at tick 3 -> asp stays 1 until tick 8, then IDLE.
REQ-024 Dry-tank abort and mode latch: DRIP entered (T=1); toggle T=0 -> got stays 1; drop low at tick 2 -> IDLE next cycle, got=0.
REQ-025 Inconsistent sensors: high=1, mid=0 in IDLE -> FAULT; ack=1 while still inconsistent -> stays FAULT; with the macro, alarme toggles per tick.
REQ-026 Reset mid-operation: assert rst_n=0 during SPRINKLE -> asp=0, state=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/irrigation_scheduler.sv
// ============================================================================
// irrigation_scheduler
//
// Purpose:
//   Tank-fill and irrigation controller. Keeps the water tank topped up from
//   the supply valve and waters with either the sprinklers or the drippers,
//   depending on weather conditions sampled at the moment a run starts.
//   Inconsistent level sensors or a fill that takes too long latch a fault
//   that the operator has to acknowledge.
//
// Parameters:
//   MIN_ON   minimum irrigation run, in ticks (1..255)
//   FILL_TO  maximum fill time before a fault, in ticks (1..255)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   tick           in   one-cycle timebase pulse; all timing counts these
//   low/mid/high   in   tank level at or above the matching sensor
//   Us             in   soil dry (irrigation demand)
//   Ua             in   air humidity high
//   T              in   temperature high
//   ack            in   operator fault acknowledge (level)
//   watter_supply  out  fill valve open
//   asp            out  sprinkler on
//   got            out  dripper on
//   error          out  sensor or fill fault latched
//   alarme         out  operator alarm
//   state          out  current FSM state code
//
// Build option:
//   IRRIG_ALARM_BLINK_EN  when defined, alarme blinks (toggles per tick) while
//                         in FAULT, starting at 1; otherwise it is held at 1.
// ============================================================================
module irrigation_scheduler #(
    parameter int unsigned MIN_ON  = 8,
    parameter int unsigned FILL_TO = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       low,
    input  logic       mid,
    input  logic       high,
    input  logic       Us,
    input  logic       Ua,
    input  logic       T,
    input  logic       ack,
    output logic       watter_supply,
    output logic       asp,
    output logic       got,
    output logic       error,
    output logic       alarme,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_SPRINKLE = 3'd2,
        ST_DRIP     = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam logic [7:0] MIN_ON_C  = 8'(MIN_ON);
    localparam logic [7:0] FILL_TO_C = 8'(FILL_TO);
    localparam logic [7:0] TIMER_MAX = 8'hFF;

    state_t     cur_state;
    state_t     nxt_state;
    logic [7:0] timer;
    logic [7:0] timer_nxt;
    logic       alarme_nxt;
    logic       inconsistent;

    // A higher sensor reporting water while a lower one is dry can only be a
    // sensor failure.
    assign inconsistent = (mid && !low) || (high && !mid);

    // Next-state selection. Sprinkle versus drip is decided only when leaving
    // IDLE, so weather changes during a run never switch the watering mode.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_IDLE: begin
                if (inconsistent)           nxt_state = ST_FAULT;
                else if (!mid)              nxt_state = ST_FILL;
                else if (Us && (T || !Ua))  nxt_state = ST_DRIP;
                else if (Us)                nxt_state = ST_SPRINKLE;
                else if (!high)             nxt_state = ST_FILL;
            end
            ST_FILL: begin
                if (inconsistent)             nxt_state = ST_FAULT;
                else if (high)                nxt_state = ST_IDLE;
                else if (timer >= FILL_TO_C)  nxt_state = ST_FAULT;
            end
            ST_SPRINKLE, ST_DRIP: begin
                // An empty tank aborts the run at once, regardless of MIN_ON.
                if (inconsistent)                     nxt_state = ST_FAULT;
                else if (!low)                        nxt_state = ST_IDLE;
                else if (!Us && (timer >= MIN_ON_C))  nxt_state = ST_IDLE;
            end
            ST_FAULT: begin
                if (ack && !inconsistent)  nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Timer counts ticks spent in the current state. A state change clears it
    // even when a tick arrives on the same cycle, and it sticks at 255.
    always_comb begin
        timer_nxt = timer;
        if (nxt_state != cur_state) begin
            timer_nxt = 8'd0;
        end else if (tick && (timer != TIMER_MAX)) begin
            timer_nxt = timer + 8'd1;
        end
    end

    // Alarm value for the state being entered.
    always_comb begin
        alarme_nxt = 1'b0;
`ifdef IRRIG_ALARM_BLINK_EN
        if (nxt_state == ST_FAULT) begin
            if (cur_state != ST_FAULT) begin
                alarme_nxt = 1'b1;
            end else if (tick) begin
                alarme_nxt = !alarme;
            end else begin
                alarme_nxt = alarme;
            end
        end
`else
        alarme_nxt = (nxt_state == ST_FAULT);
`endif
    end

    // State, timer and all outputs are registered together so the outputs
    // always describe the state entered on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state     <= ST_IDLE;
            timer         <= 8'd0;
            watter_supply <= 1'b0;
            asp           <= 1'b0;
            got           <= 1'b0;
            error         <= 1'b0;
            alarme        <= 1'b0;
        end else begin
            cur_state     <= nxt_state;
            timer         <= timer_nxt;
            watter_supply <= (nxt_state == ST_FILL);
            asp           <= (nxt_state == ST_SPRINKLE);
            got           <= (nxt_state == ST_DRIP);
            error         <= (nxt_state == ST_FAULT);
            alarme        <= alarme_nxt;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// ============================================================================
// tb_irrigation_scheduler
//
// Directed scenarios followed by a long randomized run. Every cycle the DUT
// outputs are compared with a behavioural model of the scheduler that tracks
// the controller mode and the ticks elapsed in it as plain integers.
// ============================================================================
module tb_irrigation_scheduler;

    localparam int MIN_ON  = 8;
    localparam int FILL_TO = 30;

    // Mode codes as seen on the state output.
    localparam int M_IDLE = 0, M_FILL = 1, M_SPRINKLE = 2, M_DRIP = 3, M_FAULT = 4;

    logic       clk;
    logic       rst_n;
    logic       tick, low, mid, high, Us, Ua, T, ack;
    logic       watter_supply, asp, got, error, alarme;
    logic [2:0] state;

    int total;
    int bad;

    // Reference model state: current mode, ticks since entering it, alarm.
    int m_mode;
    int m_ticks;
    bit m_alarm;

    irrigation_scheduler #(.MIN_ON(MIN_ON), .FILL_TO(FILL_TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .low          (low),
        .mid          (mid),
        .high         (high),
        .Us           (Us),
        .Ua           (Ua),
        .T            (T),
        .ack          (ack),
        .watter_supply(watter_supply),
        .asp          (asp),
        .got          (got),
        .error        (error),
        .alarme       (alarme),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the run is bounded, but never let it hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void model_reset();
        m_mode  = M_IDLE;
        m_ticks = 0;
        m_alarm = 1'b0;
    endfunction

    // One clock edge of the scheduler's rules, applied to the sampled inputs.
    function automatic void model_step(input bit tk, lo, mi, hi, us, ua, t, ak);
        bit broken;
        int next_mode;
        broken    = (mi && !lo) || (hi && !mi);
        next_mode = m_mode;
        if (m_mode == M_IDLE) begin
            if (broken)                   next_mode = M_FAULT;
            else if (!mi)                 next_mode = M_FILL;
            else if (us && (t || !ua))    next_mode = M_DRIP;
            else if (us)                  next_mode = M_SPRINKLE;
            else if (!hi)                 next_mode = M_FILL;
        end else if (m_mode == M_FILL) begin
            if (broken)                   next_mode = M_FAULT;
            else if (hi)                  next_mode = M_IDLE;
            else if (m_ticks >= FILL_TO)  next_mode = M_FAULT;
        end else if (m_mode == M_SPRINKLE || m_mode == M_DRIP) begin
            if (broken)                            next_mode = M_FAULT;
            else if (!lo)                          next_mode = M_IDLE;
            else if (!us && m_ticks >= MIN_ON)     next_mode = M_IDLE;
        end else begin
            if (ak && !broken)            next_mode = M_IDLE;
        end

`ifdef IRRIG_ALARM_BLINK_EN
        if (next_mode != M_FAULT)        m_alarm = 1'b0;
        else if (m_mode != M_FAULT)      m_alarm = 1'b1;
        else if (tk)                     m_alarm = !m_alarm;
`else
        m_alarm = (next_mode == M_FAULT);
`endif

        if (next_mode != m_mode)  m_ticks = 0;
        else if (tk)              m_ticks = (m_ticks >= 255) ? 255 : m_ticks + 1;
        m_mode = next_mode;
    endfunction

    // Full output vector check: {state, watter_supply, asp, got, error, alarme}.
    task automatic checkOutput(input string tag);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {state, watter_supply, asp, got, error, alarme};
        exp = {3'(m_mode), (m_mode == M_FILL), (m_mode == M_SPRINKLE),
               (m_mode == M_DRIP), (m_mode == M_FAULT), m_alarm};
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%b required=%b", tag, obs, exp);
        end
    endtask

    // Directed constant check on a single signal.
    task automatic checkConst(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d required=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the DUT and model take the edge, check.
    task automatic applyStimulus(input string tag,
                                 input bit tk, lo, mi, hi, us, ua, t, ak);
        tick = tk; low = lo; mid = mi; high = hi;
        Us = us; Ua = ua; T = t; ack = ak;
        @(posedge clk);
        model_step(tk, lo, mi, hi, us, ua, t, ak);
        #1;
        checkOutput(tag);
    endtask

    // Pulse rst_n between clock edges and check it acts without a clock edge.
    task automatic doAsyncReset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput(tag);
        checkConst({tag, "_state"}, 8'(state), 8'd0);
        checkConst({tag, "_asp"}, 8'(asp), 8'd0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bit lo, mi, hi, us, ua, t;
        int level;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        tick = 0; low = 0; mid = 0; high = 0; Us = 0; Ua = 0; T = 0; ack = 0;
        model_reset();
        #12;
        checkOutput("reset");
        rst_n = 1'b1;

        // Fill path: empty tank fills, full sensors at tick 5 return to IDLE.
        applyStimulus("fill_enter", 0, 0, 0, 0, 0, 0, 0, 0);
        checkConst("fill_valve", 8'(watter_supply), 8'd1);
        for (int i = 0; i < 4; i++) applyStimulus("fill_run", 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("fill_full", 1, 1, 1, 1, 0, 0, 0, 0);
        checkConst("fill_done_state", 8'(state), 8'd0);
        checkConst("fill_done_valve", 8'(watter_supply), 8'd0);

        // Fill timeout: high never arrives.
        applyStimulus("to_enter", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < FILL_TO + 2; i++) applyStimulus("to_run", 1, 0, 0, 0, 0, 0, 0, 0);
        checkConst("to_error", 8'(error), 8'd1);
        checkConst("to_valve", 8'(watter_supply), 8'd0);
        applyStimulus("to_ack", 0, 0, 0, 0, 0, 0, 0, 1);
        checkConst("to_ack_state", 8'(state), 8'd0);

        // Minimum run in SPRINKLE: demand drops after 3 ticks.
        applyStimulus("spr_full", 0, 1, 1, 1, 0, 1, 0, 0);
        applyStimulus("spr_enter", 0, 1, 1, 0, 1, 1, 0, 0);
        checkConst("spr_asp", 8'(asp), 8'd1);
        for (int i = 0; i < 3; i++) applyStimulus("spr_run", 1, 1, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus("spr_hold", 1, 1, 1, 0, 0, 1, 0, 0);
        checkConst("spr_min_on_asp", 8'(asp), 8'd1);
        applyStimulus("spr_exit", 0, 1, 1, 0, 0, 1, 0, 0);
        checkConst("spr_exit_state", 8'(state), 8'd0);

        // DRIP: mode is latched, an empty tank aborts immediately.
        applyStimulus("drip_enter", 0, 1, 1, 1, 1, 1, 1, 0);
        checkConst("drip_got", 8'(got), 8'd1);
        applyStimulus("drip_t_low", 1, 1, 1, 1, 1, 1, 0, 0);
        checkConst("drip_latched", 8'(got), 8'd1);
        applyStimulus("drip_run", 1, 1, 1, 1, 1, 1, 0, 0);
        applyStimulus("drip_dry", 0, 0, 0, 0, 1, 1, 0, 0);
        checkConst("drip_abort_got", 8'(got), 8'd0);

        // Inconsistent sensors: ack is refused until they agree again.
        applyStimulus("inc_idle", 0, 1, 1, 1, 0, 1, 0, 0);
        applyStimulus("inc_enter", 0, 1, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus("inc_ack_refused", 1, 1, 0, 1, 0, 1, 0, 1);
        checkConst("inc_still_fault", 8'(state), 8'd4);
        applyStimulus("inc_ack_ok", 1, 1, 1, 1, 0, 1, 0, 1);

        // Reset in the middle of a sprinkler run.
        applyStimulus("rst_enter", 0, 1, 1, 0, 1, 1, 0, 0);
        applyStimulus("rst_run", 1, 1, 1, 0, 1, 1, 0, 0);
        doAsyncReset("rst_mid_sprinkle");

        // Randomized run with slowly changing level and demand.
        level = 3; us = 0; ua = 0; t = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 19) == 0) level = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0)  us = !us;
            if ($urandom_range(0, 7) == 0)  ua = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 7) == 0)  t  = $urandom_range(0, 1) != 0;
            lo = (level >= 1); mi = (level >= 2); hi = (level >= 3);
            if ($urandom_range(0, 40) == 0) begin
                lo = $urandom_range(0, 1) != 0;
                mi = $urandom_range(0, 1) != 0;
                hi = $urandom_range(0, 1) != 0;
            end
            if ($urandom_range(0, 399) == 0) begin
                doAsyncReset("rand_reset");
            end else begin
                applyStimulus("random", $urandom_range(0, 1) != 0, lo, mi, hi, us, ua, t,
                              $urandom_range(0, 7) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
